tap_delay_line: RTL

Parametrised tapped delay line for the inband RX sample path. Holds the last DEPTH samples of a WIDTH-bit stream, advancing one position per rxstrobe. Any tap can be read by single request, or all taps in order by burst. Successor to the fixed 6x16 tap register: it adds a read handshake, reads that may share a cycle with a shift, fill tracking, flush, and burst readout for the matched-filter coefficient/correlation logic.

---
 rtl/tap_delay_line_if.sv | 36 +++
 rtl/tap_delay_line.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/tap_delay_line_if.sv
// Sample-stream, read-request and read-response signals of tap_delay_line.
// Handshake: a response beat is valid only in the cycle where data_valid=1.
// tap_err, burst_done and burst_torn only carry meaning in that cycle.
// Requests get no backpressure: rd_req/burst_start while busy=1 are ignored.
interface tap_delay_line_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 3
);
  logic             rxstrobe;
  logic [WIDTH-1:0] in_sample;
  logic             flush;
  logic [WIDTH-1:0] out_sample;
  logic             rd_req;
  logic [SEL_W-1:0] sel;
  logic             burst_start;
  logic [WIDTH-1:0] data;
  logic             data_valid;
  logic             tap_err;
  logic             busy;
  logic             burst_done;
  logic             burst_torn;
  logic [SEL_W-1:0] fill_count;
  logic             state_dbg;

  modport master (
    output rxstrobe, in_sample, flush, rd_req, sel, burst_start,
    input  out_sample, data, data_valid, tap_err, busy, burst_done,
           burst_torn, fill_count, state_dbg
  );

  modport slave (
    input  rxstrobe, in_sample, flush, rd_req, sel, burst_start,
    output out_sample, data, data_valid, tap_err, busy, burst_done,
           burst_torn, fill_count, state_dbg
  );
endinterface

// File: rtl/tap_delay_line.sv
// Tapped delay line holding the last DEPTH RX samples, with single-tap reads
// and a sequential burst readout of taps 1..DEPTH.
module tap_delay_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 6,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  tap_delay_line_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] DEPTH_S = SEL_W'(DEPTH);
  localparam logic [SEL_W-1:0] ONE_S   = SEL_W'(1);

  // Index 0 holds tap 1 (newest), index DEPTH-1 holds tap DEPTH (oldest).
  logic [WIDTH-1:0] taps_q [DEPTH];
  logic [WIDTH-1:0] taps_d [DEPTH];
  logic [SEL_W-1:0] fill_q, fill_d;
  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             torn_q, torn_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             btorn_q, btorn_d;

  logic [SEL_W-1:0] rd_idx;
  logic [WIDTH-1:0] rd_data;
  logic             in_range;

  always_comb begin
    taps_d   = taps_q;
    fill_d   = fill_q;
    state_d  = state_q;
    idx_d    = idx_q;
    torn_d   = torn_q;
    busy_d   = busy_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
    btorn_d  = 1'b0;
    rd_idx   = '0;
    rd_data  = '0;
    in_range = 1'b0;

    if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) taps_d[k] = '0;
      fill_d = '0;
    end else if (bus.rxstrobe) begin
      taps_d[0] = bus.in_sample;
      for (int k = 1; k < DEPTH; k++) taps_d[k] = taps_q[k-1];
      if (fill_q != DEPTH_S) fill_d = fill_q + ONE_S;
    end

    // Reads always see the pre-shift register contents of this edge.
    if (state_q == BURST)   rd_idx = idx_q;
    else if (bus.burst_start) rd_idx = ONE_S;
    else                    rd_idx = bus.sel;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_idx == SEL_W'(k + 1)) rd_data = taps_q[k];
    end
    in_range = (rd_idx != '0) && (rd_idx <= DEPTH_S);

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (!busy_q && bus.burst_start) begin
          if (!bus.flush) begin
            state_d = BURST;
            busy_d  = 1'b1;
            idx_d   = SEL_W'(2);
            torn_d  = bus.rxstrobe;
            valid_d = 1'b1;
            data_d  = rd_data;
            err_d   = (fill_q == '0);
          end
        end else if (!busy_q && bus.rd_req) begin
          valid_d = 1'b1;
          data_d  = in_range ? rd_data : '0;
          err_d   = !in_range || (rd_idx > fill_q);
        end
      end
      BURST: begin
        if (bus.flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          idx_d   = '0;
          torn_d  = 1'b0;
        end else begin
          valid_d = 1'b1;
          data_d  = rd_data;
          err_d   = (idx_q > fill_q);
          torn_d  = torn_q | bus.rxstrobe;
          // busy stays high through the cycle that shows the final beat.
          if (idx_q == DEPTH_S) begin
            done_d  = 1'b1;
            btorn_d = torn_q | bus.rxstrobe;
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ONE_S;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) taps_q[k] <= '0;
      fill_q  <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      torn_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      btorn_q <= 1'b0;
    end else begin
      for (int k = 0; k < DEPTH; k++) taps_q[k] <= taps_d[k];
      fill_q  <= fill_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      torn_q  <= torn_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      done_q  <= done_d;
      btorn_q <= btorn_d;
    end
  end

  assign bus.out_sample = taps_q[DEPTH-1];
  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.tap_err    = err_q;
  assign bus.busy       = busy_q;
  assign bus.burst_done = done_q;
  assign bus.burst_torn = btorn_q;
  assign bus.fill_count = fill_q;
  assign bus.state_dbg  = (state_q == BURST);

endmodule
